// File: rtl/dcache_mem_responder_pkg.sv
// Shared data-cache/memory definitions.
// Holds the line and address widths, the request/response structs used by the
// cache top, and the responder FSM state type.
package dcache_mem_responder_pkg;

  localparam int LINE_WIDTH = 128;
  localparam int ADDR_WIDTH = 32;

  typedef struct packed {
    logic                  req;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LINE_WIDTH-1:0] data;
    logic                  kill;
  } type_dcache2mem_s;

  typedef struct packed {
    logic                  ack;
    logic [LINE_WIDTH-1:0] data;
  } type_mem2dcache_s;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } type_dmem_resp_state_e;

endpackage

// File: rtl/dcache_mem_responder_array.sv
// Single-port synchronous line RAM with registered read and write enable.
// Shaped so that FPGA tools map it onto block RAM.
// Ports:
//   clk      clock
//   i_en     port enable (read when i_we=0, write when i_we=1)
//   i_we     write enable
//   i_addr   line index
//   i_wdata  write line
//   o_rdata  registered read line, holds until the next read
module dcache_mem_array #(
  parameter int LINE_WIDTH = 128,
  parameter int DEPTH      = 1024,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_addr,
  input  logic [LINE_WIDTH-1:0] i_wdata,
  output logic [LINE_WIDTH-1:0] o_rdata
);

  logic [LINE_WIDTH-1:0] r_mem [DEPTH];
  logic [LINE_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      else      r_rdata       <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dcache_mem_responder.sv
// Line-granular data-memory responder: memory side of the dcache2mem /
// mem2dcache handshake. Accepts a line fill or write-back, acks after a
// programmable latency, and honours the cache's kill.
// Optional build macro: MEM_RANDOM_STALL_EN adds 0..3 pseudo-random stall
// cycles per request from a 16-bit LFSR.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   dcache2mem_req_i    request, held until ack
//   dcache2mem_wr_i     1 = write-back, 0 = fill read
//   dcache2mem_addr_i   line-aligned byte address
//   dcache2mem_data_i   write-back line
//   dcache2mem_kill_i   abort outstanding request
//   mem2dcache_ack_o    one-cycle completion pulse
//   mem2dcache_data_o   fill line, valid in ack cycle and held afterwards
//   mem_busy_o          request in flight
//
// state | meaning
// IDLE  | waiting for a request
// BUSY  | latency countdown running
// RESP  | ack cycle; read data shown, write committed at its closing edge
module dcache_mem_responder
  import dcache_mem_responder_pkg::*;
#(
  parameter int LINE_WIDTH  = dcache_mem_responder_pkg::LINE_WIDTH,
  parameter int ADDR_WIDTH  = dcache_mem_responder_pkg::ADDR_WIDTH,
  parameter int MEM_DEPTH   = 1024,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dcache2mem_req_i,
  input  logic                  dcache2mem_wr_i,
  input  logic [ADDR_WIDTH-1:0] dcache2mem_addr_i,
  input  logic [LINE_WIDTH-1:0] dcache2mem_data_i,
  input  logic                  dcache2mem_kill_i,
  output logic                  mem2dcache_ack_o,
  output logic [LINE_WIDTH-1:0] mem2dcache_data_o,
  output logic                  mem_busy_o
);

  localparam int LSB   = $clog2(LINE_WIDTH / 8);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = 5;

  type_dmem_resp_state_e r_state, w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_wr;
  logic [IDX_W-1:0]      r_idx;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic [LINE_WIDTH-1:0] r_data_hold;

  logic [IDX_W-1:0]      w_in_idx;
  logic [CNT_W-1:0]      w_stall;
  logic [CNT_W-1:0]      w_load;
  logic                  w_accept;
  logic                  w_ram_re;
  logic                  w_commit;
  logic                  w_ack;
  logic [IDX_W-1:0]      w_ram_addr;
  logic [LINE_WIDTH-1:0] w_ram_q;
  logic                  w_unused_addr;

  assign w_in_idx      = dcache2mem_addr_i[LSB +: IDX_W];
  assign w_unused_addr = ^{dcache2mem_addr_i[ADDR_WIDTH-1:LSB+IDX_W],
                           dcache2mem_addr_i[LSB-1:0]};

`ifdef MEM_RANDOM_STALL_EN
  logic [15:0] r_lfsr;

  // Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= 16'hACE1;
    else     r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_stall = {3'b000, r_lfsr[1:0]};
`else
  assign w_stall = '0;
`endif

  assign w_load = CNT_W'(MEM_LATENCY - 1) + w_stall;

  // The RAM read is launched on the edge entering RESP so the registered
  // line is on the RAM output during the ack cycle.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_ram_re     = 1'b0;
    w_commit     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (dcache2mem_req_i && !dcache2mem_kill_i) begin
          w_accept     = 1'b1;
          w_state_next = (w_load == '0) ? RESP : BUSY;
          w_ram_re     = (w_load == '0) && !dcache2mem_wr_i;
        end
      end
      BUSY: begin
        if (dcache2mem_kill_i) begin
          w_state_next = IDLE;
        end else if (r_cnt <= CNT_W'(1)) begin
          w_state_next = RESP;
          w_ram_re     = !r_wr;
        end
      end
      RESP: begin
        w_state_next = IDLE;
        w_commit     = r_wr && !dcache2mem_kill_i && !rst;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_ram_addr = (r_state == IDLE) ? w_in_idx : r_idx;

  dcache_mem_array #(
    .LINE_WIDTH (LINE_WIDTH),
    .DEPTH      (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_en    (w_ram_re | w_commit),
    .i_we    (w_commit),
    .i_addr  (w_ram_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_wr        <= 1'b0;
      r_idx       <= '0;
      r_data_hold <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_wr    <= dcache2mem_wr_i;
        r_idx   <= w_in_idx;
        r_wdata <= dcache2mem_data_i;
        r_cnt   <= w_load;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_ack && !r_wr) r_data_hold <= w_ram_q;
    end
  end

  // Kill (or reset) in the RESP cycle suppresses ack and keeps the old line
  // on data_o, so both are gated combinationally.
  assign w_ack             = (r_state == RESP) && !dcache2mem_kill_i && !rst;
  assign mem2dcache_ack_o  = w_ack;
  assign mem2dcache_data_o = (w_ack && !r_wr) ? w_ram_q : r_data_hold;
  assign mem_busy_o        = (r_state != IDLE);

endmodule

// File: tb/tb_dcache_mem_responder.sv
module tb_dcache_mem_responder;

  localparam int LW  = 128;
  localparam int AW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [LW-1:0] wdata = '0;
  logic          kill = 1'b0;
  logic          ack;
  logic [LW-1:0] rdata_o;
  logic          busy;

  int checks = 0;
  int failures = 0;

  logic [LW-1:0] model_mem [int];
  logic [LW-1:0] model_data = '0;
  int            stall_hist [4];
  int            widx [$];

  dcache_mem_responder #(
    .LINE_WIDTH  (LW),
    .ADDR_WIDTH  (AW),
    .MEM_DEPTH   (1024),
    .MEM_LATENCY (LAT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .dcache2mem_req_i  (req),
    .dcache2mem_wr_i   (wr),
    .dcache2mem_addr_i (addr),
    .dcache2mem_data_i (wdata),
    .dcache2mem_kill_i (kill),
    .mem2dcache_ack_o  (ack),
    .mem2dcache_data_o (rdata_o),
    .mem_busy_o        (busy)
  );

  always #5 clk = ~clk;

  function automatic int line_of(input logic [AW-1:0] a);
    return int'((a / 16) % 1024);
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic bit lat_ok(input int l);
`ifdef MEM_RANDOM_STALL_EN
    return (l >= LAT) && (l <= LAT + 3);
`else
    return l == LAT;
`endif
  endfunction

  // Cache-side protocol: req stays high while the responder is busy.
  always @(negedge clk) begin
    if (!rst && busy === 1'b1 && !kill) begin
      checks++;
      if (req !== 1'b1) begin
        failures++;
        $display("FAIL req_held got=%b exp=1 t=%0t", req, $time);
      end
    end
  end

  // One transaction as the cache would issue it. abort_at = sample number
  // (1 = cycle right after acceptance) at which kill/rst is raised, 0 = none.
  task automatic do_txn(input logic t_wr, input logic [AW-1:0] t_addr,
                        input logic [LW-1:0] t_data, input int abort_at,
                        input bit abort_rst, output int lat,
                        output logic [LW-1:0] got);
    bit aborted;
    aborted = 1'b0;
    lat = 0;
    got = '0;
    req = 1'b1; wr = t_wr; addr = t_addr; wdata = t_data;
    @(posedge clk); #1;
    wr = ~t_wr; addr = $urandom(); wdata = rnd_line();
    for (int n = 1; n <= 12 && lat == 0 && !aborted; n++) begin
      if (n == abort_at) begin
        aborted = 1'b1;
        req = 1'b0;
        if (abort_rst) rst = 1'b1;
        else           kill = 1'b1;
      end
      #1;
      if (ack === 1'b1) begin
        lat = n;
        got = rdata_o;
      end
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_window got=%b exp=1 n=%0d", busy, n);
      end
      if (aborted) begin
        checks++;
        if (rdata_o !== model_data) begin
          failures++;
          $display("FAIL data_hold_on_abort got=%h exp=%h", rdata_o, model_data);
        end
      end
      @(posedge clk); #1;
    end
    req = 1'b0; kill = 1'b0; rst = 1'b0;
    checks++;
    if (ack !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after got=ack%b/busy%b exp=ack0/busy0", ack, busy);
    end
  endtask

  task automatic write_line(input logic [AW-1:0] a, input logic [LW-1:0] d);
    int l;
    logic [LW-1:0] g;
    do_txn(1'b1, a, d, 0, 1'b0, l, g);
    checks++;
    if (!lat_ok(l)) begin
      failures++;
      $display("FAIL write_latency got=%0d exp=%0d", l, LAT);
    end
    if (l > 0) model_mem[line_of(a)] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (rdata_o !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", rdata_o); end
    model_data = '0;
  endtask

  task automatic test_read_basic();
    int l;
    logic [LW-1:0] g, d;
    d = rnd_line();
    write_line(32'h0000_0040, d);
    do_txn(1'b0, 32'h0000_0040, '0, 0, 1'b0, l, g);
    checks++;
    if (!lat_ok(l)) begin failures++; $display("FAIL read_latency got=%0d exp=%0d", l, LAT); end
    checks++;
    if (g !== d) begin failures++; $display("FAIL read_data got=%h exp=%h", g, d); end
    if (l > 0) model_data = d;
    checks++;
    if (rdata_o !== model_data) begin
      failures++;
      $display("FAIL read_data_held got=%h exp=%h", rdata_o, model_data);
    end
  endtask

  task automatic test_write_read();
    int l;
    logic [LW-1:0] g, d;
    d = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0000_0001;
    write_line(32'h0000_0100, d);
    do_txn(1'b0, 32'h0000_0100, '0, 0, 1'b0, l, g);
    checks++;
    if (l == 0 || g !== d) begin
      failures++;
      $display("FAIL raw_data got=%h lat=%0d exp=%h", g, l, d);
    end
    if (l > 0) model_data = g;
  endtask

  task automatic test_kill_write();
    int l;
    logic [LW-1:0] g, old_d;
    old_d = rnd_line();
    write_line(32'h0000_0200, old_d);
    do_txn(1'b1, 32'h0000_0200, ~old_d, 1, 1'b0, l, g);
    checks++;
    if (l != 0) begin failures++; $display("FAIL kill_write_ack got=%0d exp=0", l); end
    do_txn(1'b0, 32'h0000_0200, '0, 0, 1'b0, l, g);
    checks++;
    if (l == 0 || g !== old_d) begin
      failures++;
      $display("FAIL kill_write_no_commit got=%h exp=%h", g, old_d);
    end
    if (l > 0) model_data = g;
  endtask

  task automatic test_kill_resp();
`ifndef MEM_RANDOM_STALL_EN
    int l;
    logic [LW-1:0] g;
    write_line(32'h0000_0300, rnd_line());
    do_txn(1'b0, 32'h0000_0300, '0, LAT, 1'b0, l, g);
    checks++;
    if (l != 0) begin failures++; $display("FAIL kill_resp_ack got=%0d exp=0", l); end
    checks++;
    if (rdata_o !== model_data) begin
      failures++;
      $display("FAIL kill_resp_data got=%h exp=%h", rdata_o, model_data);
    end
`endif
  endtask

  task automatic test_wrap();
    int l;
    logic [LW-1:0] g, d;
    d = rnd_line();
    write_line(32'h0000_4010, d);
    do_txn(1'b0, 32'h0000_0010, '0, 0, 1'b0, l, g);
    checks++;
    if (l == 0 || g !== d) begin failures++; $display("FAIL wrap_data got=%h exp=%h", g, d); end
    do_txn(1'b0, 32'hFFFF_C01C, '0, 0, 1'b0, l, g);
    checks++;
    if (l == 0 || g !== d) begin failures++; $display("FAIL wrap_offset got=%h exp=%h", g, d); end
    if (l > 0) model_data = g;
  endtask

  task automatic test_rst_mid();
    int l;
    logic [LW-1:0] g, d;
    d = model_mem[line_of(32'h0000_0100)];
    do_txn(1'b1, 32'h0000_0100, ~d, 1, 1'b1, l, g);
    checks++;
    if (l != 0) begin failures++; $display("FAIL rst_mid_ack got=%0d exp=0", l); end
    model_data = '0;
    checks++;
    if (rdata_o !== '0) begin failures++; $display("FAIL rst_mid_data got=%h exp=0", rdata_o); end
    do_txn(1'b0, 32'h0000_0100, '0, 0, 1'b0, l, g);
    checks++;
    if (l == 0 || g !== d) begin failures++; $display("FAIL rst_mid_no_commit got=%h exp=%h", g, d); end
    if (l > 0) model_data = g;
  endtask

  task automatic test_random();
    int l, ix;
    logic [LW-1:0] g;
    logic [AW-1:0] a;
    for (int i = 0; i < 40; i++) begin
      ix = int'($urandom_range(0, 1023));
      a = ($urandom() & 32'hFFFF_C000) | (AW'(ix) << 4) | AW'($urandom_range(0, 15));
      write_line(a, rnd_line());
      widx.push_back(ix);
    end
    for (int i = 0; i < 200; i++) begin
      ix = widx[$urandom_range(0, widx.size() - 1)];
      a = ($urandom() & 32'hFFFF_C000) | (AW'(ix) << 4) | AW'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin
        write_line(a, rnd_line());
      end else begin
        do_txn(1'b0, a, '0, 0, 1'b0, l, g);
        checks++;
        if (!lat_ok(l)) begin
          failures++;
          $display("FAIL rand_latency got=%0d exp=%0d i=%0d", l, LAT, i);
        end else begin
          stall_hist[l - LAT]++;
        end
        checks++;
        if (g !== model_mem[ix]) begin
          failures++;
          $display("FAIL rand_data got=%h exp=%h i=%0d", g, model_mem[ix], i);
        end
        if (l > 0) model_data = g;
      end
    end
`ifdef MEM_RANDOM_STALL_EN
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (stall_hist[s] == 0) begin
        failures++;
        $display("FAIL stall_cover got=0 exp>0 stall=%0d", s);
      end
    end
`endif
  endtask

  initial begin
    for (int s = 0; s < 4; s++) stall_hist[s] = 0;
    test_reset();
    test_read_basic();
    test_write_read();
    test_kill_write();
    test_kill_resp();
    test_wrap();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
